// File: rtl/axis_vadd_multi_ch.sv
// axis_vadd_multi_ch: per-channel AXI4-Stream lane adder with packet-stable constant and output FIFO
module axis_vadd_multi_ch #(
    parameter int C_NUM_CHANNELS    = 2,
    parameter int C_TDATA_WIDTH     = 512,
    parameter int C_ADDER_BIT_WIDTH = 32,
    parameter int C_SATURATE        = 0,
    parameter int C_FIFO_DEPTH      = 4
) (
    input  logic                                        ap_clk,
    input  logic                                        ap_rst_n,
    input  logic [C_NUM_CHANNELS-1:0]                   s_axis_tvalid,
    output logic [C_NUM_CHANNELS-1:0]                   s_axis_tready,
    input  logic [C_NUM_CHANNELS*C_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_CHANNELS*C_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_NUM_CHANNELS-1:0]                   s_axis_tlast,
    output logic [C_NUM_CHANNELS-1:0]                   m_axis_tvalid,
    input  logic [C_NUM_CHANNELS-1:0]                   m_axis_tready,
    output logic [C_NUM_CHANNELS*C_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_NUM_CHANNELS*C_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_NUM_CHANNELS-1:0]                   m_axis_tlast,
    input  logic [C_NUM_CHANNELS*C_ADDER_BIT_WIDTH-1:0] ctrl_constant,
    output logic [C_NUM_CHANNELS*32-1:0]                stat_beat_count,
    output logic [C_NUM_CHANNELS*32-1:0]                stat_pkt_count
);
    localparam int W  = C_TDATA_WIDTH;
    localparam int A  = C_ADDER_BIT_WIDTH;
    localparam int KW = W / 8;
    localparam int AW = $clog2(C_FIFO_DEPTH);

    for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
        logic [W-1:0]  sum_d, pd_q;
        logic [KW-1:0] pk_q;
        logic [A-1:0]  k, const_q;
        logic          body_q, pv_q, pl_q, rdy_q, s_hs, m_hs;
        logic [AW-1:0] wp_q, rp_q;
        logic [AW:0]   occ_q, occ_d;
        logic [31:0]   beats_q, pkts_q;
        logic [W-1:0]  dmem [C_FIFO_DEPTH];
        logic [KW-1:0] kmem [C_FIFO_DEPTH];
        logic          lmem [C_FIFO_DEPTH];

        // First beat of a packet uses the live constant; later beats reuse the latched one
        assign k = body_q ? const_q : ctrl_constant[c*A +: A];
        // The adder register counts as occupied so an accepted beat always has a FIFO slot
        assign s_axis_tready[c] = rdy_q && ({1'b0, occ_q} + (AW+2)'(pv_q) < (AW+2)'(C_FIFO_DEPTH));
        assign s_hs  = s_axis_tvalid[c] & s_axis_tready[c];
        assign m_hs  = m_axis_tvalid[c] & m_axis_tready[c];
        assign occ_d = occ_q + (AW+1)'(pv_q) - (AW+1)'(m_hs);

        assign m_axis_tvalid[c]              = occ_q != '0;
        assign m_axis_tdata[c*W +: W]        = dmem[rp_q];
        assign m_axis_tkeep[c*KW +: KW]      = kmem[rp_q];
        assign m_axis_tlast[c]               = lmem[rp_q];
        assign stat_beat_count[c*32 +: 32]   = beats_q;
        assign stat_pkt_count[c*32 +: 32]    = pkts_q;

        for (genvar i = 0; i < W / A; i++) begin : g_lane
            logic [A:0] s;
            assign s = {1'b0, s_axis_tdata[c*W + i*A +: A]} + {1'b0, k};
            assign sum_d[i*A +: A] = (C_SATURATE != 0 && s[A]) ? '1 : s[A-1:0];
        end

        // Control state: packet phase, adder register, FIFO pointers and statistics
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                rdy_q   <= 1'b0;
                body_q  <= 1'b0;
                const_q <= '0;
                pv_q    <= 1'b0;
                pd_q    <= '0;
                pk_q    <= '0;
                pl_q    <= 1'b0;
                wp_q    <= '0;
                rp_q    <= '0;
                occ_q   <= '0;
                beats_q <= '0;
                pkts_q  <= '0;
            end else begin
                rdy_q <= 1'b1;
                pv_q  <= s_hs;
                occ_q <= occ_d;
                if (s_hs) begin
                    pd_q   <= sum_d;
                    pk_q   <= s_axis_tkeep[c*KW +: KW];
                    pl_q   <= s_axis_tlast[c];
                    body_q <= !s_axis_tlast[c];
                    if (!body_q) const_q <= ctrl_constant[c*A +: A];
                end
                if (pv_q) wp_q <= wp_q + AW'(1);
                if (m_hs) begin
                    rp_q    <= rp_q + AW'(1);
                    beats_q <= beats_q + 32'd1;
                    pkts_q  <= pkts_q + 32'(lmem[rp_q]);
                end
            end
        end

        // FIFO storage; contents need no reset because occupancy gates visibility
        always_ff @(posedge ap_clk) begin
            if (pv_q) begin
                dmem[wp_q] <= pd_q;
                kmem[wp_q] <= pk_q;
                lmem[wp_q] <= pl_q;
            end
        end
    end
endmodule
